// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and iteration constants.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  localparam int unsigned MDU_ITERS = 32;
  localparam logic [5:0]  MDU_LAST  = 6'(MDU_ITERS - 1);

  function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic is_neg);
    return is_neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per cycle, with a 6-bit iteration counter.
module mdu_iter_core
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] acc_lo_init,
  input  logic [31:0] opnd_init,
  output logic [63:0] acc,
  output logic        last
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;

  logic [32:0] rem_sh;
  logic [31:0] trial;
  logic [32:0] sum;

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;

    // Divide: acc holds {remainder, dividend/quotient}; the shifted remainder
    // can reach 33 bits, but after a successful subtract it fits in 32.
    rem_sh = acc_q[63:31];
    trial  = rem_sh[31:0] - opnd_q;
    // Multiply: acc holds {partial product, multiplier}; carry enters bit 63.
    sum    = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'h0)};

    if (load) begin
      acc_d    = {32'h0, acc_lo_init};
      opnd_d   = opnd_init;
      cnt_d    = '0;
      is_div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q + 6'd1;
      if (is_div_q) begin
        if (rem_sh >= {1'b0, opnd_q}) begin
          acc_d = {trial, acc_q[30:0], 1'b1};
        end else begin
          acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  assign acc  = acc_q;
  assign last = step && (cnt_q == MDU_LAST);

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit controller: operand capture, sign handling, result
// registers and done/div_by_zero reporting around the iterative core.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  mdu_state_e  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic [31:0] a_q, a_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        b_zero_q, b_zero_d;

  logic        is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        core_load, core_step, core_last;
  logic [63:0] core_acc;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & operand_a[31];
  assign b_neg     = is_signed & operand_b[31];
  assign a_mag     = mdu_mag(operand_a, a_neg);
  assign b_mag     = mdu_mag(operand_b, b_neg);

  assign prod_fix = neg_res_q ? (64'd0 - core_acc) : core_acc;
  assign quo_fix  = neg_res_q ? (32'd0 - core_acc[31:0]) : core_acc[31:0];
  assign rem_fix  = neg_rem_q ? (32'd0 - core_acc[63:32]) : core_acc[63:32];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    core_load = 1'b0;
    core_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_load = 1'b1;
          a_d       = operand_a;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_zero_d  = (operand_b == 32'h0);
          dbz_d     = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (b_zero_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Mult loads the multiplier into the low half and keeps the multiplicand
  // as the addend; divide loads the dividend low and keeps the divisor.
  mdu_iter_core u_core (
    .clk         (clk),
    .reset       (reset),
    .load        (core_load),
    .step        (core_step),
    .is_div      (op[1]),
    .acc_lo_init (op[1] ? a_mag : b_mag),
    .opnd_init   (op[1] ? b_mag : a_mag),
    .acc         (core_acc),
    .last        (core_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
